// File: rtl/sram_port_arbiter.sv
// Two-master Avalon-MM front end for a single-port SRAM: round-robin grant per cycle,
// one-stage read return steered to the issuing master, out-of-range accesses absorbed.
module sram_port_arbiter #(
  parameter int DEPTH  = 10240,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic                sram_clken,
  input  logic [DATA_W-1:0]   sram_readdata,
  output logic                oob_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic req0, req1;
  logic grant0, grant1, grant_any;
  logic gnt_write, in_range;

  logic last_grant_q, last_grant_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic rd_oob_q, rd_oob_d;
  logic oob_err_q, oob_err_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // On conflict the master that did not win last time goes first; nothing is granted in reset.
  assign grant0    = ~reset & req0 & (~req1 | last_grant_q);
  assign grant1    = ~reset & req1 & (~req0 | ~last_grant_q);
  assign grant_any = grant0 | grant1;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  assign sram_address    = grant1 ? m1_address    : m0_address;
  assign sram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign sram_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign gnt_write       = grant1 ? m1_write      : m0_write;
  assign in_range        = ({1'b0, sram_address} < DEPTH_L);

  assign sram_chipselect = grant_any & in_range;
  assign sram_write      = sram_chipselect & gnt_write;
  assign sram_clken      = 1'b1;

  always_comb begin
    last_grant_d = last_grant_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    rd_oob_d     = rd_oob_q;
    oob_err_d    = oob_err_q;
    if (grant_any) begin
      last_grant_d = grant1;
      if (!in_range) begin
        oob_err_d = 1'b1;
      end
      if (!gnt_write) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = grant1;
        rd_oob_d   = ~in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_oob_q     <= 1'b0;
      oob_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      rd_oob_q     <= rd_oob_d;
      oob_err_q    <= oob_err_d;
    end
  end

  // Gating with reset squashes a read return that would land in the first reset cycle.
  assign m0_readdatavalid = rd_pend_q & ~reset & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & ~reset &  rd_owner_q;
  assign m0_readdata      = rd_oob_q ? '0 : sram_readdata;
  assign m1_readdata      = rd_oob_q ? '0 : sram_readdata;
  assign oob_err          = oob_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized bench for sram_port_arbiter with an SRAM model and a
// cycle-level reference model of arbitration, memory contents and read returns.
module tb_sram_port_arbiter;
  localparam int DEPTH = 10240;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect, sram_write, sram_clken;
  logic [31:0] sram_writedata, sram_readdata;
  logic        oob_err;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_clken(sram_clken),
    .sram_readdata(sram_readdata), .oob_err(oob_err)
  );

  // SRAM device: byte-enabled write, registered read.
  logic [31:0] sram_mem [0:DEPTH-1];
  logic [31:0] sram_rd_r;
  assign sram_readdata = sram_rd_r;
  always @(posedge clk) begin
    if (sram_chipselect && sram_clken) begin
      if (sram_write) begin
        for (int b = 0; b < 4; b++)
          if (sram_byteenable[b]) sram_mem[sram_address][b*8 +: 8] <= sram_writedata[b*8 +: 8];
      end else begin
        sram_rd_r <= sram_mem[sram_address];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [int];
  bit          m_last, m_pend, m_owner, m_oob, m_wait0, m_wait1;
  logic [31:0] m_data;
  int          n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit r0, input bit w0, input logic [13:0] a0,
                      input logic [3:0] be0, input logic [31:0] d0,
                      input bit r1, input bit w1, input logic [13:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1);
    bit q0, q1, g0, g1, ev0, ev1, ww, inr, cs;
    int wa;
    logic [3:0]  wbe;
    logic [31:0] wd, nv;
    reset = rst;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    #1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    if (rst) begin
      g0 = 0; g1 = 0;
    end else if (q0 && q1) begin
      g0 = m_last; g1 = !m_last;
    end else begin
      g0 = q0; g1 = q1;
    end
    ev0 = !rst && m_pend && !m_owner;
    ev1 = !rst && m_pend &&  m_owner;
    chk("rdvalid0", m0_readdatavalid, ev0);
    chk("rdvalid1", m1_readdatavalid, ev1);
    if (ev0) chk("rdata0", m0_readdata, m_data);
    if (ev1) chk("rdata1", m1_readdata, m_data);
    chk("wait0", m0_waitrequest, q0 && !g0);
    chk("wait1", m1_waitrequest, q1 && !g1);
    wa  = g1 ? int'(a1) : int'(a0);
    wbe = g1 ? be1 : be0;
    wd  = g1 ? d1 : d0;
    ww  = g1 ? w1 : w0;
    inr = wa < DEPTH;
    cs  = (g0 || g1) && inr;
    chk("chipselect", sram_chipselect, cs);
    chk("sram_write", sram_write, cs && ww);
    if (g0 || g1) chk("sram_addr", sram_address, wa);
    if (cs && ww) begin
      chk("sram_wdata", sram_writedata, wd);
      chk("sram_be", sram_byteenable, wbe);
    end
    chk("oob_err", oob_err, m_oob);
    m_pend = 0;
    if (rst) begin
      m_last = 1; m_oob = 0;
    end else if (g0 || g1) begin
      m_last = g1;
      if (!inr) m_oob = 1;
      if (ww) begin
        if (inr) begin
          nv = ref_rd(wa);
          for (int b = 0; b < 4; b++) if (wbe[b]) nv[b*8 +: 8] = wd[b*8 +: 8];
          ref_mem[wa] = nv;
        end
      end else begin
        m_pend = 1; m_owner = g1; m_data = inr ? ref_rd(wa) : 32'h0;
      end
    end
    m_wait0 = q0 && !g0;
    m_wait1 = q1 && !g1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 14'h0, 4'h0, 32'h0, 0, 0, 14'h0, 4'h0, 32'h0);
  endtask

  function automatic logic [13:0] rnd_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6) return 14'($urandom_range(0, 7));
    if (s < 8) return 14'($urandom_range(DEPTH - 4, DEPTH - 1));
    if (s < 9) return 14'($urandom_range(DEPTH, DEPTH + 3));
    return 14'h3FFF;
  endfunction

  bit          rr0, rw0, rr1, rw1, rst_r;
  logic [13:0] ra0, ra1;
  logic [3:0]  rb0, rb1;
  logic [31:0] rd0, rd1;

  initial begin
    for (int i = 0; i < DEPTH; i++) sram_mem[i] = 32'h0;
    sram_rd_r = 32'h0;
    reset = 1;
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    m_last = 1; m_pend = 0; m_owner = 0; m_oob = 0; m_data = 0;
    repeat (2) @(posedge clk);
    #1;
    // Requests held in reset must all be stalled.
    step(1, 1, 0, 14'h10, 4'hF, 32'h0, 1, 0, 14'h20, 4'hF, 32'h0);
    step(0, 0, 1, 14'h0, 4'hF, 32'h0BADF00D, 0, 0, 14'h0, 4'h0, 32'h0);

    // m0 alone: write then read back.
    step(0, 0, 1, 14'h10, 4'hF, 32'hDEADBEEF, 0, 0, 14'h0, 4'h0, 32'h0);
    step(0, 1, 0, 14'h10, 4'hF, 32'h0, 0, 0, 14'h0, 4'h0, 32'h0);
    chk("t1_data", m0_readdata, 32'hDEADBEEF);
    idle(0);

    // Both read every cycle right after reset: strict alternation starting with m0.
    idle(1);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 14'h10, 4'hF, 32'h0, 1, 0, 14'h0, 4'hF, 32'h0);
    idle(0);

    // Partial write by m1, read by m0.
    step(0, 0, 0, 14'h0, 4'h0, 32'h0, 0, 1, 14'h100, 4'hF, 32'hFFFFFFFF);
    step(0, 0, 0, 14'h0, 4'h0, 32'h0, 0, 1, 14'h100, 4'h3, 32'h12345678);
    step(0, 1, 0, 14'h100, 4'hF, 32'h0, 0, 0, 14'h0, 4'h0, 32'h0);
    chk("t3_data", m0_readdata, 32'hFFFF5678);
    idle(0);

    // Out-of-range write and read.
    step(0, 0, 1, 14'(DEPTH), 4'hF, 32'hA5A5A5A5, 0, 0, 14'h0, 4'h0, 32'h0);
    step(0, 1, 0, 14'(DEPTH), 4'hF, 32'h0, 0, 0, 14'h0, 4'h0, 32'h0);
    chk("t4_data", m0_readdata, 32'h0);
    step(0, 1, 0, 14'h0, 4'hF, 32'h0, 0, 0, 14'h0, 4'h0, 32'h0);
    chk("t4_word0", m0_readdata, 32'h0BADF00D);
    idle(0);
    chk("t4_sticky", oob_err, 1'b1);

    // Reset right after an m1 read is accepted; m0 wins the first conflict afterwards.
    step(0, 0, 0, 14'h0, 4'h0, 32'h0, 1, 0, 14'h10, 4'hF, 32'h0);
    idle(1);
    idle(1);
    step(0, 1, 0, 14'h10, 4'hF, 32'h0, 1, 0, 14'h100, 4'hF, 32'h0);
    idle(0);

    // Randomized traffic; a stalled master holds its request.
    for (int i = 0; i < 500; i++) begin
      if (!m_wait0) begin
        case ($urandom_range(0, 3))
          0: begin rr0 = 0; rw0 = 0; end
          1: begin rr0 = 1; rw0 = 0; end
          2: begin rr0 = 0; rw0 = 1; end
          default: begin rr0 = 1; rw0 = 1; end
        endcase
        ra0 = rnd_addr(); rb0 = 4'($urandom_range(0, 15)); rd0 = $urandom;
      end
      if (!m_wait1) begin
        case ($urandom_range(0, 3))
          0: begin rr1 = 0; rw1 = 0; end
          1: begin rr1 = 1; rw1 = 0; end
          2: begin rr1 = 0; rw1 = 1; end
          default: begin rr1 = 1; rw1 = 0; end
        endcase
        ra1 = rnd_addr(); rb1 = 4'($urandom_range(0, 15)); rd1 = $urandom;
      end
      rst_r = ($urandom_range(0, 63) == 0);
      step(rst_r, rr0, rw0, ra0, rb0, rd0, rr1, rw1, ra1, rb1, rd1);
    end
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
